// File: rtl/udp_rx.sv
`default_nettype none
// ============================================================================
// Module   : udp_rx
// Purpose  : UDP receive layer. Consumes an IP-layer AXI-Stream (one packet =
//            one last-delimited IP fragment), strips the 8-byte UDP header and
//            forwards the payload to the user stream. Fragmented datagrams are
//            reassembled in order. A fragment whose offset does not continue
//            the current datagram closes that datagram with a zero-keep
//            terminating beat. Datagrams that are not accepted are discarded.
//
// Ports    : i_clk, i_rst_n          clock, asynchronous active-low reset
//            i_dymanic_dst_port/valid new local port and its load strobe
//            s_axis_ip_*             64-bit IP stream in; byte 0 in data[63:56]
//                                    user = {len, flags, type, offset, id}
//            m_axis_user_*           64-bit payload stream out
//                                    user = {UDP src port, payload bytes}
//            o_drop_pulse            one pulse per discarded datagram
//            o_frag_err              one pulse per fragment-offset mismatch
//
// Config   : UDP_RX_PORT_FILTER_EN   when defined, the UDP destination port
//                                    must equal the local port register.
//                                    When undefined, only the IP protocol
//                                    type is checked and i_dymanic_dst_* are
//                                    ignored.
//
// Revision : 1.0  initial release
// ============================================================================
module udp_rx #(
    parameter logic [15:0] P_LOCAL_UDP_PORT = 16'h8080
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [15:0] i_dymanic_dst_port,
    input  logic        i_dymanic_dst_valid,
    input  logic [63:0] s_axis_ip_data,
    input  logic [7:0]  s_axis_ip_keep,
    input  logic        s_axis_ip_last,
    input  logic        s_axis_ip_valid,
    output logic        s_axis_ip_ready,
    input  logic [55:0] s_axis_ip_user,
    output logic [63:0] m_axis_user_data,
    output logic [7:0]  m_axis_user_keep,
    output logic        m_axis_user_last,
    output logic        m_axis_user_valid,
    input  logic        m_axis_user_ready,
    output logic [31:0] m_axis_user_user,
    output logic        o_drop_pulse,
    output logic        o_frag_err
);

    localparam logic [1:0] c_st_idle    = 2'd0;
    localparam logic [1:0] c_st_pass    = 2'd1;
    localparam logic [1:0] c_st_drop    = 2'd2;
    localparam logic [2:0] c_flags_more = 3'b001;
    localparam logic [7:0] c_proto_udp  = 8'd17;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [1:0]  r_state;
    logic [15:0] r_src;
    logic [15:0] r_pay_len;
    logic [12:0] r_exp_off;
    logic        r_frag_start;   // next accepted beat opens a continuation fragment
    logic        r_out_valid;
    logic [63:0] r_out_data;
    logic [7:0]  r_out_keep;
    logic        r_out_last;
    logic [31:0] r_out_user;
    logic        r_drop_pulse;
    logic        r_frag_err;

    // ------------------------------------------------------------------------
    // Input field decode
    // ------------------------------------------------------------------------
    logic [15:0] w_in_len;
    logic [2:0]  w_in_flags;
    logic [7:0]  w_in_type;
    logic [12:0] w_in_off;
    logic [15:0] w_hdr_src;
    logic [15:0] w_hdr_len;
    logic        w_acc;
    logic        w_frag_end;
    logic        w_port_ok;
    logic        w_hdr_ok;
    logic        w_off_ok;
    logic [12:0] w_next_off;
    logic        w_unused;

    assign w_in_len   = s_axis_ip_user[55:40];
    assign w_in_flags = s_axis_ip_user[39:37];
    assign w_in_type  = s_axis_ip_user[36:29];
    assign w_in_off   = s_axis_ip_user[28:16];
    assign w_hdr_src  = s_axis_ip_data[63:48];
    assign w_hdr_len  = s_axis_ip_data[31:16];

    assign s_axis_ip_ready = !r_out_valid || m_axis_user_ready;
    assign w_acc           = s_axis_ip_valid && s_axis_ip_ready;

    // Last beat of a fragment that also ends its datagram.
    assign w_frag_end = s_axis_ip_last && (w_in_flags != c_flags_more);

    // Fragment offsets count 8-byte units, so the IP length drops its low bits.
    assign w_next_off = w_in_off + w_in_len[15:3];

    // An offset of zero on a continuation fragment means a new datagram began
    // before the current one finished, which is treated as a mismatch.
    assign w_off_ok = (w_in_off == r_exp_off) && (w_in_off != 13'd0);

`ifdef UDP_RX_PORT_FILTER_EN
    logic [15:0] r_local_port;

    // Only sampled on header beats, so an update landing mid-datagram
    // first applies to the following datagram.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_local_port <= P_LOCAL_UDP_PORT;
        end else if (i_dymanic_dst_valid) begin
            r_local_port <= i_dymanic_dst_port;
        end
    end

    assign w_port_ok = (s_axis_ip_data[47:32] == r_local_port);
    assign w_unused  = &{1'b0, s_axis_ip_user[15:0], w_in_len[2:0]};
`else
    assign w_port_ok = 1'b1;
    assign w_unused  = &{1'b0, s_axis_ip_user[15:0], w_in_len[2:0],
                         i_dymanic_dst_port, i_dymanic_dst_valid, P_LOCAL_UDP_PORT};
`endif

    assign w_hdr_ok = (w_in_type == c_proto_udp) && w_port_ok && (w_hdr_len >= 16'd8);

    // ------------------------------------------------------------------------
    // Control FSM and output register
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= c_st_idle;
            r_src        <= 16'd0;
            r_pay_len    <= 16'd0;
            r_exp_off    <= 13'd0;
            r_frag_start <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_data   <= 64'd0;
            r_out_keep   <= 8'hFF;
            r_out_last   <= 1'b0;
            r_out_user   <= 32'd0;
            r_drop_pulse <= 1'b0;
            r_frag_err   <= 1'b0;
        end else begin
            r_drop_pulse <= 1'b0;
            r_frag_err   <= 1'b0;

            if (r_out_valid && m_axis_user_ready) begin
                r_out_valid <= 1'b0;
            end

            if (w_acc) begin
                case (r_state)
                    c_st_idle: begin
                        if ((w_in_off != 13'd0) || !w_hdr_ok) begin
                            // A single-beat fragment that closes the datagram
                            // is finished already; otherwise discard the rest.
                            if (w_frag_end) begin
                                r_drop_pulse <= 1'b1;
                            end else begin
                                r_state <= c_st_drop;
                            end
                        end else begin
                            r_src        <= w_hdr_src;
                            r_pay_len    <= w_hdr_len - 16'd8;
                            r_frag_start <= 1'b0;
                            if (!s_axis_ip_last) begin
                                r_state <= c_st_pass;
                            end else if (w_in_flags == c_flags_more) begin
                                // Header-only first fragment: payload follows
                                // in later fragments.
                                r_state      <= c_st_pass;
                                r_exp_off    <= w_next_off;
                                r_frag_start <= 1'b1;
                            end
                            // Header-only complete datagram: nothing to emit.
                        end
                    end

                    c_st_pass: begin
                        if (r_frag_start && !w_off_ok) begin
                            // Close the datagram with an empty terminating beat.
                            r_out_valid  <= 1'b1;
                            r_out_data   <= 64'd0;
                            r_out_keep   <= 8'h00;
                            r_out_last   <= 1'b1;
                            r_out_user   <= {r_src, r_pay_len};
                            r_frag_err   <= 1'b1;
                            r_frag_start <= 1'b0;
                            r_exp_off    <= 13'd0;
                            if (w_frag_end) begin
                                r_drop_pulse <= 1'b1;
                                r_state      <= c_st_idle;
                            end else begin
                                r_state <= c_st_drop;
                            end
                        end else begin
                            r_out_valid  <= 1'b1;
                            r_out_data   <= s_axis_ip_data;
                            r_out_keep   <= w_frag_end ? s_axis_ip_keep : 8'hFF;
                            r_out_last   <= w_frag_end;
                            r_out_user   <= {r_src, r_pay_len};
                            r_frag_start <= 1'b0;
                            if (w_frag_end) begin
                                r_state   <= c_st_idle;
                                r_exp_off <= 13'd0;
                            end else if (s_axis_ip_last) begin
                                r_exp_off    <= w_next_off;
                                r_frag_start <= 1'b1;
                            end
                        end
                    end

                    c_st_drop: begin
                        if (w_frag_end) begin
                            r_drop_pulse <= 1'b1;
                            r_state      <= c_st_idle;
                        end
                    end

                    default: begin
                        r_state <= c_st_idle;
                    end
                endcase
            end
        end
    end

    assign m_axis_user_valid = r_out_valid;
    assign m_axis_user_data  = r_out_data;
    assign m_axis_user_keep  = r_out_keep;
    assign m_axis_user_last  = r_out_last;
    assign m_axis_user_user  = r_out_user;
    assign o_drop_pulse      = r_drop_pulse;
    assign o_frag_err        = r_frag_err;

endmodule
`default_nettype wire

// File: doc/udp_rx.md
UDP_RX -- requirements
Module: udp_rx

Interface
REQ-001 Parameter P_LOCAL_UDP_PORT, default 16'h8080, dst port accepted after reset.
REQ-002 i_clk  input  1  sole clock; all logic rising-edge.
REQ-003 i_rst_n  input  1  asynchronous, active-low reset.
REQ-004 i_dymanic_dst_port  input  16  new local port, loaded when i_dymanic_dst_valid=1.
REQ-005 i_dymanic_dst_valid  input  1  load strobe for i_dymanic_dst_port.
REQ-006 s_axis_ip_data/keep/last/valid/ready  in/in/in/in/out  64/8/1/1/1  IP-layer stream; byte 0 in data[63:56].
REQ-007 s_axis_ip_user  input  56  {len[55:40], flags[39:37], type[36:29], offset[28:16], id[15:0]}; len = IP payload bytes, flags 010 = unfragmented, 001 = more fragments, 000 = last fragment; offset in 8-byte units.
REQ-008 m_axis_user_data/keep/last/valid/ready  out/out/out/out/in  64/8/1/1/1  payload stream to user.
REQ-009 m_axis_user_user  output  32  {UDP src port, payload byte length}.
REQ-010 o_drop_pulse  output  1  one-cycle pulse per discarded datagram.
REQ-011 o_frag_err  output  1  one-cycle pulse on fragment-offset mismatch.

Function
REQ-012 States IDLE, PASS, DROP; a packet is one s_axis_ip last-delimited fragment.
REQ-013 Beat accepted when s_axis_ip_valid && s_axis_ip_ready; s_axis_ip_ready = !out_valid || m_axis_user_ready (single output register, latency 1 cycle, no bubbles under continuous ready).
REQ-014 IDLE, first beat with offset=0: beat is the UDP header {src, dst, udp_len, csum}; header beat never forwarded; latch src and payload length = udp_len-8.
REQ-015 Header accepted if type=17 and dst = local port; else -> DROP.
REQ-016 Header beat with last=1 (udp_len=8, flags 010): no output, return IDLE.
REQ-017 PASS: forward beats unchanged; m_axis_user_user constant for whole datagram.
REQ-018 m_axis_user_last=1 only on last beat of a fragment whose flags != 001; keep copied from input on that beat, 8'hFF otherwise.
REQ-019 Fragment end with flags=001: expected_offset = offset + len/8; stay PASS awaiting next fragment, no last output.
REQ-020 Next fragment first beat: offset = expected_offset -> forward all its beats (no header strip); mismatch or offset=0 -> emit one beat last=1 keep=8'h00 data=0, pulse o_frag_err, enter DROP for the mismatched fragment's datagram.
REQ-021 IDLE receiving a fragment with offset != 0: DROP that fragment, pulse o_drop_pulse.
REQ-022 DROP: consume beats with ready=1, no output; exit to IDLE on last of a fragment with flags != 001; o_drop_pulse once on exit.
REQ-023 Local port update takes effect at next datagram header; mid-datagram update has no effect on current datagram.
REQ-024 Length arithmetic 16-bit unsigned; udp_len < 8 -> DROP.

Reset
REQ-025 On i_rst_n=0: state IDLE, local port = P_LOCAL_UDP_PORT, expected_offset=0, m_axis_user_valid/last=0, data/user=0, keep=8'hFF, o_drop_pulse=0, o_frag_err=0, s_axis_ip_ready=1 after release.
REQ-026 Reset mid-datagram discards it; no terminating beat emitted.

Configuration
REQ-027 Macro UDP_RX_PORT_FILTER_EN defined: dst-port mismatch -> DROP per REQ-015.
REQ-028 Macro undefined: dst port ignored, only type checked; i_dymanic_dst_* unused.

Verification
REQ-029 Unfragmented: header dst 8080, udp_len 108, 13 payload beats, last keep 8'hF0 -> 13 out beats, user {src,16'd100}, last keep 8'hF0.
REQ-030 Fragmented 3000 B: fragments offset 0/185/370, len 1480/1480/48, flags 001/001/000 -> 375 contiguous out beats, single last, user length 3000.
REQ-031 Filter on, dst 16'h04D2 -> zero output beats, o_drop_pulse one cycle after input last.
REQ-032 Second fragment offset 200 (expected 185) -> terminating beat last=1 keep=8'h00, o_frag_err pulse, remaining fragments dropped.
REQ-033 m_axis_user_ready low 5 cycles mid-datagram -> s_axis_ip_ready low, no beat lost/duplicated, data order preserved.
REQ-034 i_rst_n asserted mid-PASS -> outputs at reset values; next clean datagram received correctly.
